wdt_ctrl: RTL and testbench
===========================

# wdt_ctrl

Software-facing control and reset-generation stage for the 32-bit watchdog timer. It drives the timer's load value, enable and overflow-clear inputs, and consumes the timer's count and overflow flag. It implements:
- a lock/unlock key for register protection;
- a two-stage timeout policy: first timeout raises an interrupt, a second timeout with the interrupt still pending requests a system reset.

It sits between the peripheral bus decoder and the watchdog timer instance.

## Interface
Parameters:
- RST_CYCLES, 16: width of sys_rst_req_o pulse in clk cycles (≥1).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_i  in  1  register write strobe, one cycle per write.
- addr_i  in  2  register word address.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data, combinational from addr_i.
- wdload_o  out  32  timer load value (LOAD register).
- wden_o  out  1  timer enable (CTRL.EN).
- wdovclr_o  out  1  timer overflow-clear pulse.
- wdtmr_i  in  32  timer current count.
- wdov_i  in  1  timer overflow flag.
- irq_o  out  1  watchdog interrupt, high in WARN.
- sys_rst_req_o  out  1  system reset request pulse.

## Operation
Register map (word address):
- 0 LOAD: RW, reset 0.
- 1 CTRL: RW.
  - bit0 EN, bit1 RSTEN; reset 0.
  - bit2 INTCLR: write-1 issues a clear; reads 0.
- 2 STATUS: RO.
  - bit0 wdov_i, bit1 locked, bits3:2 state (IDLE=0, ARMED=1, WARN=2, RESET=3).
- 3 write: KEY. 3 read: wdtmr_i (VALUE).

Lock rules:
- Writes to LOAD/CTRL are ignored while locked. Reset state is locked.
- Writing KEY=0x1ACC_E551 unlocks. Writing any other KEY value locks.
- KEY is always writable.
- All writes, including KEY, are ignored while in RESET.

State machine (registered):
- IDLE: entered when EN=0. Goes to ARMED when EN=1.
- ARMED: goes to WARN when wdov_i=1 is sampled.
- WARN: irq_o=1; clears left_zero on entry.
  - Sets left_zero when wdtmr_i≠0.
  - Goes to ARMED when wdov_i=0 is sampled (i.e. after software clear).
  - Goes to RESET when wdtmr_i==0 and left_zero=1 and RSTEN=1.
  - With RSTEN=0, stays in WARN.
- RESET: sys_rst_req_o=1 for exactly RST_CYCLES cycles. Then: EN←0, one wdovclr_o pulse, → IDLE.
- Any state with EN cleared by write → IDLE, plus one wdovclr_o pulse. This overrides everything except RESET.

wdovclr_o fires on: a CTRL write with INTCLR=1 (unlocked), EN 1→0, or RESET exit. Each fire is a single-cycle pulse; coincident causes produce one pulse.

Outputs at reset: rdata_o follows addr_i; all others 0.

## Timing
- Register write accepted at the clk edge where wr_i=1. wdload_o/wden_o update at that same edge (visible next cycle).
- wdovclr_o is registered: high during the cycle after the INTCLR write edge. The timer's WDOV drops one edge later; WARN→ARMED follows one cycle after that.
- State transitions use values sampled at the edge; irq_o and sys_rst_req_o come from state flops (no combinational path from inputs).
- Reset counter is $clog2(RST_CYCLES+1) bits, loaded on RESET entry, exit at terminal count.
- rst_n low at any point, including mid-RESET, returns every flop to its reset value at the next edge. The reset pulse is truncated.

## Configuration
- WDT_LOCK_EN defined: key/lock behaviour as above.
- WDT_LOCK_EN undefined:
  - block permanently unlocked; STATUS.locked reads 0;
  - KEY writes ignored;
  - lock flop and comparator absent.

## Structure
Shared package wdt_pkg holds:
- state enum;
- register address constants;
- CTRL bit indices;
- the KEY unlock constant.

One sub-module, wdt_rst_pulse (RESET-state counter and pulse generator), parameterised by RST_CYCLES. The rest is flat.

## Test plan
- Locked after reset; write LOAD=100 → wdload_o stays 0. Write KEY=0x1ACCE551, then LOAD=100 → wdload_o=100. Write KEY=0 → STATUS.locked=1.
- Unlocked; LOAD=20, CTRL=0x1 with timer attached → ARMED; timer expires → irq_o=1, STATUS.state=2.
- In WARN, write CTRL=0x5 → wdovclr_o high 1 cycle; wdov_i drops → irq_o=0, state ARMED. No reset requested.
- LOAD=20, CTRL=0x3; let both timeouts pass without clear → sys_rst_req_o high exactly 16 cycles. Then wden_o=0, one wdovclr_o pulse, state IDLE.
- Same as previous, with rst_n asserted 5 cycles into RESET → next edge sys_rst_req_o=0, wden_o=0, locked=1.
- RSTEN=0, two timeouts → state remains WARN, sys_rst_req_o never asserts. Clear EN → IDLE with one wdovclr_o pulse.

Source files
------------

// File: rtl/wdt_pkg.sv
// wdt_pkg: shared types and constants for the watchdog control block.
package wdt_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WARN  = 2'd2,
    ST_RESET = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LOAD   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_KEY    = 2'd3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_RSTEN  = 1;
  localparam int unsigned CTRL_INTCLR = 2;

  localparam logic [DATA_W-1:0] KEY_UNLOCK = 32'h1ACC_E551;

  // STATUS read word layout
  typedef struct packed {
    logic [27:0] rsvd;
    state_t      state;
    logic        locked;
    logic        wdov;
  } status_t;

endpackage

// File: rtl/wdt_rst_pulse.sv
// wdt_rst_pulse: counts the RESET state and generates the reset request pulse.
module wdt_rst_pulse
  import wdt_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic pulse,
  output logic done_c
);

  localparam int unsigned CNT_W = $clog2(RST_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // Last cycle of the pulse: counter has reached its terminal value
  assign done_c = pulse && (cnt == '0);

  // Load on RESET entry, count down while the pulse is high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (start) begin
      cnt   <= CNT_W'(RST_CYCLES - 1);
      pulse <= 1'b1;
    end else if (pulse) begin
      if (done_c) pulse <= 1'b0;
      else        cnt   <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/wdt_ctrl.sv
// wdt_ctrl: register interface, lock key and two-stage timeout policy for the
// watchdog timer. Define WDT_LOCK_EN to build the KEY lock; without it the
// block is permanently unlocked and KEY writes are ignored.
module wdt_ctrl
  import wdt_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] wdload_o,
  output logic        wden_o,
  output logic        wdovclr_o,
  input  logic [31:0] wdtmr_i,
  input  logic        wdov_i,
  output logic        irq_o,
  output logic        sys_rst_req_o
);

  state_t            state, state_next;
  logic [DATA_W-1:0] load_q;
  logic              en_q, rsten_q, left_zero_q, clr_q, irq_q;
  logic              locked;
  logic              wr_ok_c, load_wr_c, ctrl_wr_c, en_clr_c;
  logic              rst_start_c, rst_done_c, clr_next_c;
  status_t           status_c;

  // Writes are frozen while the reset request is being driven
  assign wr_ok_c   = wr_i && (state != ST_RESET);
  assign load_wr_c = wr_ok_c && !locked && (addr_i == ADDR_LOAD);
  assign ctrl_wr_c = wr_ok_c && !locked && (addr_i == ADDR_CTRL);
  assign en_clr_c  = ctrl_wr_c && !wdata_i[CTRL_EN];

`ifdef WDT_LOCK_EN
  logic locked_q;

  // Lock flop: only the exact key unlocks, any other key value locks
  always_ff @(posedge clk) begin
    if (!rst_n)                              locked_q <= 1'b1;
    else if (wr_ok_c && addr_i == ADDR_KEY)  locked_q <= (wdata_i != KEY_UNLOCK);
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  // Next-state logic; a software EN clear overrides all but RESET
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (en_q) state_next = ST_ARMED;
      ST_ARMED: if (wdov_i) state_next = ST_WARN;
      ST_WARN: begin
        if (!wdov_i)
          state_next = ST_ARMED;
        else if ((wdtmr_i == '0) && left_zero_q && rsten_q)
          state_next = ST_RESET;
      end
      ST_RESET: if (rst_done_c) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (en_clr_c) state_next = ST_IDLE;
  end

  assign rst_start_c = (state != ST_RESET) && (state_next == ST_RESET);
  assign clr_next_c  = (ctrl_wr_c && wdata_i[CTRL_INTCLR]) ||
                       (en_clr_c && en_q) || rst_done_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // LOAD/CTRL registers; RESET exit drops EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_q  <= '0;
      en_q    <= 1'b0;
      rsten_q <= 1'b0;
    end else begin
      if (load_wr_c) load_q <= wdata_i;
      if (ctrl_wr_c) begin
        en_q    <= wdata_i[CTRL_EN];
        rsten_q <= wdata_i[CTRL_RSTEN];
      end else if (rst_done_c) begin
        en_q <= 1'b0;
      end
    end
  end

  // WARN bookkeeping, overflow-clear pulse and interrupt flop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      left_zero_q <= 1'b0;
      clr_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (state != ST_WARN && state_next == ST_WARN) left_zero_q <= 1'b0;
      else if (state == ST_WARN && wdtmr_i != '0)    left_zero_q <= 1'b1;
      clr_q <= clr_next_c;
      irq_q <= (state_next == ST_WARN);
    end
  end

  wdt_rst_pulse #(.RST_CYCLES(RST_CYCLES)) u_rst_pulse (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (rst_start_c),
    .pulse  (sys_rst_req_o),
    .done_c (rst_done_c)
  );

  // Read mux, combinational from the address
  always_comb begin
    status_c        = '0;
    status_c.state  = state;
    status_c.locked = locked;
    status_c.wdov   = wdov_i;
    rdata_o         = '0;
    case (addr_i)
      ADDR_LOAD: rdata_o = load_q;
      ADDR_CTRL: begin
        rdata_o[CTRL_EN]    = en_q;
        rdata_o[CTRL_RSTEN] = rsten_q;
      end
      ADDR_STATUS: rdata_o = status_c;
      default:     rdata_o = wdtmr_i;
    endcase
  end

  assign wdload_o  = load_q;
  assign wden_o    = en_q;
  assign wdovclr_o = clr_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_wdt_ctrl.sv
// tb_wdt_ctrl: directed scenarios plus randomized traffic, checked through a
// scoreboard fed by a behavioural model of the watchdog control rules.
module tb_wdt_ctrl;

  localparam int unsigned RST_CYCLES = 16;
  localparam logic [31:0] KEY = 32'h1ACC_E551;
`ifdef WDT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, wr;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata, wdload;
  logic        wden, wdovclr, irq, sysrst;
  logic        attached;
  logic [31:0] r_tmr, t_cnt, tmr_drv;
  logic        r_ov, t_ov, ov_drv;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] load;
    bit          en;
    bit          rsten;
    bit          locked;
    int          phase;
    bit          clr;
  } exp_t;

  exp_t q[$];

  assign tmr_drv = attached ? t_cnt : r_tmr;
  assign ov_drv  = attached ? t_ov  : r_ov;

  wdt_ctrl #(.RST_CYCLES(RST_CYCLES)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_i          (wr),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .rdata_o       (rdata),
    .wdload_o      (wdload),
    .wden_o        (wden),
    .wdovclr_o     (wdovclr),
    .wdtmr_i       (tmr_drv),
    .wdov_i        (ov_drv),
    .irq_o         (irq),
    .sys_rst_req_o (sysrst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    cyc();
    wr = 1'b0;
  endtask

  function automatic logic sig(input int sel);
    return (sel == 0) ? irq : sysrst;
  endfunction

  task automatic wait_for(input int sel, input logic val, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (sig(sel) == val) break;
      cyc();
    end
    chk(name, 32'(sig(sel)), 32'(val));
  endtask

  // Simple down-counting timer: reloads and flags overflow at zero
  always @(posedge clk) begin
    if (!rst_n) begin
      t_cnt <= '0;
      t_ov  <= 1'b0;
    end else begin
      if (wdovclr) t_ov <= 1'b0;
      if (!wden) t_cnt <= wdload;
      else if (t_cnt == 0) begin
        t_cnt <= wdload;
        t_ov  <= 1'b1;
      end else begin
        t_cnt <= t_cnt - 32'd1;
      end
    end
  end

  // Reference model: phase 0 idle, 1 armed, 2 warning, 3 reset request
  logic [31:0] m_load;
  bit          m_en, m_rsten, m_locked, m_lz, m_clr;
  int          m_phase, m_rst_left;

  always @(posedge clk) begin : ref_model
    bit wok, wctrl, old_en;
    int np;
    if (!rst_n) begin
      m_load = '0; m_en = 0; m_rsten = 0; m_locked = LOCK_EN;
      m_phase = 0; m_lz = 0; m_rst_left = 0; m_clr = 0;
    end else begin
      wok    = wr && (m_phase != 3);
      wctrl  = wok && (addr == 2'd1) && !m_locked;
      old_en = m_en;
      m_clr  = 0;
      np     = m_phase;
      if (m_phase == 3) begin
        m_rst_left--;
        if (m_rst_left == 0) begin np = 0; m_en = 0; m_clr = 1; end
      end else if (wctrl && !wdata[0]) begin
        np = 0;
      end else begin
        case (m_phase)
          0: if (m_en) np = 1;
          1: if (ov_drv) np = 2;
          2: if (!ov_drv) np = 1;
             else if (tmr_drv == 0 && m_lz && m_rsten) begin
               np = 3; m_rst_left = RST_CYCLES;
             end
          default: ;
        endcase
      end
      if (np == 2 && m_phase != 2) m_lz = 0;
      else if (m_phase == 2 && tmr_drv != 0) m_lz = 1;
      m_phase = np;
      if (wok && addr == 2'd0 && !m_locked) m_load = wdata;
      if (wctrl) begin
        m_en = wdata[0]; m_rsten = wdata[1];
        if (wdata[2] || (old_en && !wdata[0])) m_clr = 1;
      end
`ifdef WDT_LOCK_EN
      if (wok && addr == 2'd3) m_locked = (wdata != KEY);
`endif
    end
    q.push_back('{m_load, m_en, m_rsten, m_locked, m_phase, m_clr});
  end

  // Monitor: every cycle the DUT presents its outputs; compare with the model
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [31:0] er;
    if (q.size() != 0) begin
      e  = q.pop_front();
      er = '0;
      case (addr)
        2'd0: er = e.load;
        2'd1: er = {30'd0, e.rsten, e.en};
        2'd2: er = {28'd0, 2'(e.phase), e.locked, ov_drv};
        default: er = tmr_drv;
      endcase
      chk("wdload", wdload, e.load);
      chk("wden", 32'(wden), 32'(e.en));
      chk("wdovclr", 32'(wdovclr), 32'(e.clr));
      chk("irq", 32'(irq), 32'(e.phase == 2));
      chk("sys_rst_req", 32'(sysrst), 32'(e.phase == 3));
      chk("rdata", rdata, er);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int w, c;
    bit seen;
    rst_n = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    attached = 1'b0; r_tmr = '0; r_ov = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Lock behaviour
    addr = 2'd2; #1;
    chk("locked_after_reset", 32'(rdata[1]), 32'(LOCK_EN));
    wr_reg(2'd0, 32'd100);
    chk("load_while_locked", wdload, LOCK_EN ? 32'd0 : 32'd100);
    wr_reg(2'd3, KEY);
    wr_reg(2'd0, 32'd100);
    chk("load_unlocked", wdload, 32'd100);
    wr_reg(2'd3, 32'd0);
    addr = 2'd2; #1;
    chk("locked_after_bad_key", 32'(rdata[1]), 32'(LOCK_EN));
    wr_reg(2'd3, KEY);

    // First timeout raises the interrupt
    wr_reg(2'd0, 32'd20);
    attached = 1'b1;
    wr_reg(2'd1, 32'h1);
    wait_for(0, 1'b1, 100, "irq_raise");
    addr = 2'd2; #1;
    chk("state_warn", 32'(rdata[3:2]), 32'd2);

    // Software clear returns to ARMED
    wr_reg(2'd1, 32'h5);
    chk("intclr_pulse", 32'(wdovclr), 32'd1);
    cyc();
    chk("intclr_single", 32'(wdovclr), 32'd0);
    wait_for(0, 1'b0, 10, "irq_clear");
    addr = 2'd2; #1;
    chk("state_armed", 32'(rdata[3:2]), 32'd1);
    chk("no_rst_after_clear", 32'(sysrst), 32'd0);

    // Two timeouts with RSTEN: full reset pulse
    wr_reg(2'd1, 32'h0);
    wr_reg(2'd0, 32'd20);
    wr_reg(2'd1, 32'h3);
    wait_for(1, 1'b1, 200, "rst_req_rise");
    w = 0;
    while (sysrst && w < 100) begin w++; cyc(); end
    chk("rst_width", 32'(w), 32'(RST_CYCLES));
    chk("exit_ovclr", 32'(wdovclr), 32'd1);
    chk("exit_en", 32'(wden), 32'd0);
    addr = 2'd2; #1;
    chk("exit_state_idle", 32'(rdata[3:2]), 32'd0);
    cyc();
    chk("exit_ovclr_single", 32'(wdovclr), 32'd0);

    // Reset pulse truncated by rst_n
    wr_reg(2'd1, 32'h3);
    wait_for(1, 1'b1, 200, "rst_req_rise2");
    repeat (5) cyc();
    rst_n = 1'b0;
    cyc();
    chk("trunc_rst_req", 32'(sysrst), 32'd0);
    chk("trunc_en", 32'(wden), 32'd0);
    rst_n = 1'b1;
    addr = 2'd2; #1;
    chk("trunc_locked", 32'(rdata[1]), 32'(LOCK_EN));

    // RSTEN=0: stays in WARN, then EN clear
    wr_reg(2'd3, KEY);
    wr_reg(2'd0, 32'd20);
    wr_reg(2'd1, 32'h1);
    wait_for(0, 1'b1, 100, "irq_raise2");
    seen = 1'b0;
    repeat (80) begin cyc(); if (sysrst) seen = 1'b1; end
    chk("no_rst_rsten0", 32'(seen), 32'd0);
    chk("irq_held", 32'(irq), 32'd1);
    addr = 2'd2; #1;
    chk("state_warn_held", 32'(rdata[3:2]), 32'd2);
    wr_reg(2'd1, 32'h0);
    c = int'(wdovclr);
    repeat (4) begin cyc(); c += int'(wdovclr); end
    chk("en_clr_pulses", 32'(c), 32'd1);
    addr = 2'd2; #1;
    chk("en_clr_idle", 32'(rdata[3:2]), 32'd0);
    chk("en_clr_irq", 32'(irq), 32'd0);

    // Randomized traffic against the model
    attached = 1'b0;
    repeat (3000) begin
      rst_n = ($urandom_range(63) != 0);
      r_ov  = ($urandom_range(3) != 0);
      r_tmr = ($urandom_range(3) == 0) ? 32'd0 : 32'($urandom);
      addr  = 2'($urandom_range(3));
      wr    = ($urandom_range(2) == 0);
      case (addr)
        2'd1: wdata = {29'd0, ($urandom_range(3) == 0), 1'($urandom_range(1)),
                       ($urandom_range(7) != 0)};
        2'd3: wdata = ($urandom_range(1) != 0) ? KEY : 32'($urandom);
        default: wdata = 32'($urandom);
      endcase
      cyc();
    end
    rst_n = 1'b1; wr = 1'b0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
